// File: rtl/fsk_window_decider.sv
// -----------------------------------------------------------------------------
// fsk_window_decider
//
// Purpose:
//   Window controller and FSK symbol decider for the tone-classifying
//   frequency analyzer. Each window clears the analyzer, lets it accumulate
//   for WINDOW_TICKS clocks, flushes the pending half-period, captures the
//   three tick totals and decides one symbol. The decision is presented on a
//   one-entry valid/ready result register.
//
// Parameters:
//   WINDOW_TICKS       measurement window length in clocks (16..2^31-1)
//   MIN_SHARE_PERCENT  share of the window one tone must hold (51..100)
//
// Ports:
//   clock            single clock, rising edge
//   clear            synchronous active-low reset
//   run              level; windows execute back-to-back while high
//   f0_value         analyzer f0 tick total
//   f1_value         analyzer f1 tick total
//   unknown          analyzer unassigned tick total
//   analyzer_enable  to analyzer enable (registered)
//   analyzer_clear   to analyzer clear, active-low (registered)
//   symbol_valid     result register holds an unread symbol
//   symbol_ready     consumer accepts the symbol
//   symbol_bit       0 = f0 dominant, 1 = f1 dominant
//   symbol_erasure   neither tone reached the threshold (symbol_bit = 0)
//   window_error     captured f0+f1+unknown differs from WINDOW_TICKS
//   overrun          sticky; a decided symbol was dropped
//   overrun_count    (FSK_DECIDER_OVERRUN_COUNT_EN only) saturating count of
//                    dropped symbols
//
// Optional feature macro: FSK_DECIDER_OVERRUN_COUNT_EN
// -----------------------------------------------------------------------------
module fsk_window_decider #(
   parameter int unsigned WINDOW_TICKS      = 50000,
   parameter int unsigned MIN_SHARE_PERCENT = 60
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        run,
   input  logic [31:0] f0_value,
   input  logic [31:0] f1_value,
   input  logic [31:0] unknown,
   output logic        analyzer_enable,
   output logic        analyzer_clear,
   output logic        symbol_valid,
   input  logic        symbol_ready,
   output logic        symbol_bit,
   output logic        symbol_erasure,
   output logic        window_error,
   output logic        overrun
`ifdef FSK_DECIDER_OVERRUN_COUNT_EN
   ,
   output logic [15:0] overrun_count
`endif
);

   typedef enum logic [2:0] {
      IDLE,
      CLR,
      MEASURE,
      FLUSH,
      CAPTURE,
      DECIDE
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] tick_cnt;

   logic [31:0] f0_hold_p0;
   logic [31:0] f1_hold_p0;
   logic [31:0] unk_hold_p0;

   logic [33:0] total_p1;
   logic [40:0] thresh_p1;
   logic [40:0] share1_p1;
   logic [40:0] share0_p1;
   logic        bit_p1;
   logic        erasure_p1;
   logic        werr_p1;
   logic        result_free;

`ifdef FSK_DECIDER_OVERRUN_COUNT_EN
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction
`endif

   // Next-state logic. run is only looked at in IDLE and DECIDE so that a
   // window in progress always completes.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (run) state_nxt = CLR;
         CLR:     state_nxt = MEASURE;
         MEASURE: if (tick_cnt == 32'(WINDOW_TICKS - 1)) state_nxt = FLUSH;
         FLUSH:   state_nxt = CAPTURE;
         CAPTURE: state_nxt = DECIDE;
         DECIDE:  state_nxt = run ? CLR : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Decide stage: share comparison done as tone*100 >= total*percent so no
   // division is needed; widths cover three full 32-bit totals times 100.
   always_comb begin
      total_p1   = {2'b00, f0_hold_p0} + {2'b00, f1_hold_p0} + {2'b00, unk_hold_p0};
      thresh_p1  = 41'(total_p1) * 41'(MIN_SHARE_PERCENT);
      share1_p1  = 41'(f1_hold_p0) * 41'd100;
      share0_p1  = 41'(f0_hold_p0) * 41'd100;
      bit_p1     = 1'b0;
      erasure_p1 = 1'b0;
      if (share1_p1 >= thresh_p1) begin
         bit_p1 = 1'b1;
      end else if (share0_p1 < thresh_p1) begin
         erasure_p1 = 1'b1;
      end
      werr_p1    = (total_p1 != 34'(WINDOW_TICKS));
   end

   assign result_free = !symbol_valid || symbol_ready;

   always_ff @(posedge clock) begin
      if (!clear) begin
         state           <= IDLE;
         tick_cnt        <= '0;
         analyzer_enable <= 1'b0;
         analyzer_clear  <= 1'b1;
         f0_hold_p0      <= '0;
         f1_hold_p0      <= '0;
         unk_hold_p0     <= '0;
         symbol_valid    <= 1'b0;
         symbol_bit      <= 1'b0;
         symbol_erasure  <= 1'b0;
         window_error    <= 1'b0;
         overrun         <= 1'b0;
`ifdef FSK_DECIDER_OVERRUN_COUNT_EN
         overrun_count   <= '0;
`endif
      end else begin
         state <= state_nxt;

         // Analyzer controls are registered from the next state so they line
         // up exactly with the state they belong to.
         analyzer_enable <= (state_nxt == MEASURE);
         analyzer_clear  <= (state_nxt != CLR);

         if (state == CLR) begin
            tick_cnt <= '0;
         end else if (state == MEASURE) begin
            tick_cnt <= tick_cnt + 32'd1;
         end

         // Capture stage: analyzer totals are stable after the flush cycle.
         if (state == CAPTURE) begin
            f0_hold_p0  <= f0_value;
            f1_hold_p0  <= f1_value;
            unk_hold_p0 <= unknown;
         end

         // Result stage: a DECIDE reload takes precedence over the handshake
         // clearing valid in the same cycle.
         if (state == DECIDE) begin
            if (result_free) begin
               symbol_valid   <= 1'b1;
               symbol_bit     <= bit_p1;
               symbol_erasure <= erasure_p1;
               window_error   <= werr_p1;
            end else begin
               overrun        <= 1'b1;
`ifdef FSK_DECIDER_OVERRUN_COUNT_EN
               overrun_count  <= sat_inc16(overrun_count);
`endif
            end
         end else if (symbol_valid && symbol_ready) begin
            symbol_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fsk_window_decider.sv
// -----------------------------------------------------------------------------
// tb_fsk_window_decider
//
// Bench for fsk_window_decider with a short window. The analyzer is modelled
// by driving its three totals directly; each window's totals are applied just
// after the previous symbol appears and are captured late in the window.
// Expected symbols come from a percentage-share model of the decision rule.
// -----------------------------------------------------------------------------
module tb_fsk_window_decider;

   localparam int unsigned W   = 50;
   localparam int unsigned PCT = 60;
   localparam int          NDIR  = 8;
   localparam int          NRAND = 30;

   logic        clock = 1'b0;
   logic        clear;
   logic        run;
   logic [31:0] f0_value;
   logic [31:0] f1_value;
   logic [31:0] unknown;
   logic        analyzer_enable;
   logic        analyzer_clear;
   logic        symbol_valid;
   logic        symbol_ready;
   logic        symbol_bit;
   logic        symbol_erasure;
   logic        window_error;
   logic        overrun;
`ifdef FSK_DECIDER_OVERRUN_COUNT_EN
   logic [15:0] overrun_count;
`endif

   always #5 clock = ~clock;

   fsk_window_decider #(
      .WINDOW_TICKS      (W),
      .MIN_SHARE_PERCENT (PCT)
   ) dut (
      .clock           (clock),
      .clear           (clear),
      .run             (run),
      .f0_value        (f0_value),
      .f1_value        (f1_value),
      .unknown         (unknown),
      .analyzer_enable (analyzer_enable),
      .analyzer_clear  (analyzer_clear),
      .symbol_valid    (symbol_valid),
      .symbol_ready    (symbol_ready),
      .symbol_bit      (symbol_bit),
      .symbol_erasure  (symbol_erasure),
      .window_error    (window_error),
      .overrun         (overrun)
`ifdef FSK_DECIDER_OVERRUN_COUNT_EN
      ,
      .overrun_count   (overrun_count)
`endif
   );

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   logic exp_bit;
   logic exp_era;
   logic exp_err;

   // Directed windows: exact threshold, one tick below, all unknown, f0
   // dominant, short total, 32-bit extremes.
   logic [31:0] d_f0  [NDIR] = '{32'd10, 32'd10, 32'd0,  32'd40, 32'd10, 32'd30,
                                  32'h1000_0000, 32'hFFFF_FFFF};
   logic [31:0] d_f1  [NDIR] = '{32'd30, 32'd29, 32'd0,  32'd5,  32'd20, 32'd10,
                                  32'hF000_0000, 32'hFFFF_FFFF};
   logic [31:0] d_unk [NDIR] = '{32'd10, 32'd11, 32'd50, 32'd5,  32'd19, 32'd10,
                                  32'd0,         32'hFFFF_FFFF};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clock);
      @(negedge clock);
      cyc++;
   endtask

   // A tone is decided when its ticks are at least PCT percent of all ticks
   // in the window; f1 is tested first.
   function automatic void model(input logic [31:0] f0, input logic [31:0] f1,
                                 input logic [31:0] unk,
                                 output logic b, output logic e, output logic w);
      longint total;
      total = longint'(f0) + longint'(f1) + longint'(unk);
      b = 1'b0;
      e = 1'b0;
      if (longint'(f1) * 100 >= total * longint'(PCT))      b = 1'b1;
      else if (longint'(f0) * 100 >= total * longint'(PCT)) b = 1'b0;
      else                                                  e = 1'b1;
      w = (total != longint'(W));
   endfunction

   task automatic apply(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] au);
      f0_value = a0;
      f1_value = a1;
      unknown  = au;
      model(a0, a1, au, exp_bit, exp_era, exp_err);
   endtask

   task automatic apply_random();
      int unsigned r1, r0, ru, k;
      k  = $urandom_range(0, 3);
      r1 = $urandom_range(0, W);
      r0 = $urandom_range(0, W - r1);
      ru = W - r0 - r1;
      if (k == 0 && ru > 0) ru = ru - 1;
      if (k == 1)           ru = ru + 1;
      apply(r0, r1, ru);
   endtask

   task automatic wait_valid(input int budget);
      int n;
      n = 0;
      while (!symbol_valid && n < budget) begin
         step();
         n++;
      end
      if (!symbol_valid) chk("valid_timeout", 32'd0, 32'd1);
   endtask

   task automatic chk_sym(input string tag, input logic b, input logic e, input logic w);
      chk({tag, "_valid"},   32'(symbol_valid),   32'd1);
      chk({tag, "_bit"},     32'(symbol_bit),     32'(b));
      chk({tag, "_erasure"}, 32'(symbol_erasure), 32'(e));
      chk({tag, "_werr"},    32'(window_error),   32'(w));
   endtask

   initial begin
      int   n;
      int   c0;
      logic hb, he, hw;

      clear        = 1'b0;
      run          = 1'b1;
      symbol_ready = 1'b1;
      apply(d_f0[0], d_f1[0], d_unk[0]);

      // Reset held with run high
      repeat (3) step();
      chk("rst_enable",  32'(analyzer_enable), 32'd0);
      chk("rst_aclear",  32'(analyzer_clear),  32'd1);
      chk("rst_valid",   32'(symbol_valid),    32'd0);
      chk("rst_bit",     32'(symbol_bit),      32'd0);
      chk("rst_erasure", 32'(symbol_erasure),  32'd0);
      chk("rst_werr",    32'(window_error),    32'd0);
      chk("rst_overrun", 32'(overrun),         32'd0);
`ifdef FSK_DECIDER_OVERRUN_COUNT_EN
      chk("rst_ovcount", 32'(overrun_count),   32'd0);
`endif

      // First window: clear pulse, enable length, latency
      clear = 1'b1;
      step();
      c0 = cyc;
      chk("clr_pulse",   32'(analyzer_clear),  32'd0);
      chk("clr_enable",  32'(analyzer_enable), 32'd0);
      step();
      chk("clr_release", 32'(analyzer_clear),  32'd1);
      n = 0;
      while (analyzer_enable && n < int'(W) + 8) begin
         n++;
         step();
      end
      chk("enable_len", 32'(n), 32'(W));
      wait_valid(8);
      chk("latency", 32'(cyc - c0), 32'(W + 4));
      chk_sym("dir0", exp_bit, exp_era, exp_err);

      // Back-to-back windows, directed then random
      for (int i = 1; i < NDIR + NRAND; i++) begin
         if (i < NDIR) apply(d_f0[i], d_f1[i], d_unk[i]);
         else          apply_random();
         c0 = cyc;
         step();
         chk("pulse_drop", 32'(symbol_valid), 32'd0);
         wait_valid(int'(W) + 8);
         chk("period", 32'(cyc - c0), 32'(W + 4));
         chk_sym($sformatf("win%0d", i), exp_bit, exp_era, exp_err);
      end
      chk("no_overrun_yet", 32'(overrun), 32'd0);

      // Consumer stalls: first symbol held, second dropped
      apply(32'd40, 32'd5, 32'd5);
      step();
      chk("consumed", 32'(symbol_valid), 32'd0);
      symbol_ready = 1'b0;
      wait_valid(int'(W) + 8);
      chk_sym("held1", exp_bit, exp_era, exp_err);
      hb = exp_bit;
      he = exp_era;
      hw = exp_err;
      apply(32'd5, 32'd45, 32'd0);
      repeat (W + 4) step();
      chk_sym("kept1", hb, he, hw);
      chk("overrun_set", 32'(overrun), 32'd1);
`ifdef FSK_DECIDER_OVERRUN_COUNT_EN
      chk("ovcount_1", 32'(overrun_count), 32'd1);
`endif

      // Ready asserted during DECIDE: reload wins, overrun untouched
      apply(32'd0, 32'd0, 32'd50);
      repeat (W + 3) step();
      symbol_ready = 1'b1;
      step();
      symbol_ready = 1'b0;
      chk_sym("reload", exp_bit, exp_era, exp_err);
      chk("overrun_kept", 32'(overrun), 32'd1);
`ifdef FSK_DECIDER_OVERRUN_COUNT_EN
      chk("ovcount_kept", 32'(overrun_count), 32'd1);
`endif
      step();
      chk("still_held", 32'(symbol_valid), 32'd1);
      symbol_ready = 1'b1;
      step();
      chk("drained", 32'(symbol_valid), 32'd0);

      // run dropped mid-window: window completes, then block idles
      run = 1'b0;
      wait_valid(int'(W) + 8);
      chk_sym("last", exp_bit, exp_era, exp_err);
      for (int i = 0; i < 12; i++) begin
         step();
         chk("idle_enable", 32'(analyzer_enable), 32'd0);
         chk("idle_aclear", 32'(analyzer_clear),  32'd1);
      end
      chk("idle_valid", 32'(symbol_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
